linear_mac_engine: RTL and testbench

Parametrised fully-connected (linear) layer engine for the KWS inference datapath. It buffers one IN_DIM-element signed input vector and fetches weights and biases from the weight SRAM over a Wishbone classic master port. For each of OUT_DIM output neurons it computes a fixed-point dot product plus bias and streams the saturated results out through a valid/ready handshake.

---
 rtl/linear_mac_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_linear_mac_engine.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linear_mac_engine.sv
// Fully-connected layer engine: buffers one input vector, fetches weights/biases over a
// Wishbone classic master and streams saturated Q-format dot products. Optional macro: LINEAR_RELU_EN.
module linear_mac_engine #(
    parameter int DATA_W    = 32,
    parameter int IN_DIM    = 20,
    parameter int OUT_DIM   = 12,
    parameter int ADDR_W    = 10,
    parameter int W_BASE    = 0,
    parameter int B_BASE    = 960,
    parameter int FRAC_BITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_index,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    input  logic [DATA_W-1:0] wbm_dat_i,
    input  logic              wbm_ack_i
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + $clog2(IN_DIM);
    localparam int SUM_W  = ACC_W + 2;
    localparam int IDX_W  = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam logic [7:0] IN_LAST  = 8'(IN_DIM - 1);
    localparam logic [7:0] OUT_LAST = 8'(OUT_DIM - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_FETCH_W = 3'd2,
        ST_MAC     = 3'd3,
        ST_FETCH_B = 3'd4,
        ST_EMIT    = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [7:0]                k_q, k_d, i_q, i_d, o_q, o_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [DATA_W-1:0]  w_q, w_d;
    logic [ADDR_W-1:0]         w_ptr_q, w_ptr_d;
    logic signed [DATA_W-1:0]  x_buf_q [IN_DIM];
    logic signed [DATA_W-1:0]  x_buf_d [IN_DIM];
    logic signed [PROD_W-1:0]  prod_s;
    logic [DATA_W-1:0]         out_data_q, out_data_d;
    logic [7:0]                out_index_q, out_index_d;
    logic                      done_q, done_d, busy_q, busy_d;
    logic                      in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic                      cyc_q, cyc_d;
    logic [3:0]                sel_q, sel_d;
    logic [ADDR_W-1:0]         adr_q, adr_d;

    // Bias is aligned to the product's binary point before the floor shift, then clamped.
    function automatic logic [DATA_W-1:0] sat_result(input logic signed [ACC_W-1:0] acc,
                                                     input logic signed [DATA_W-1:0] bias);
        logic signed [SUM_W-1:0] sum;
        logic [DATA_W-1:0]       res;
        sum = (SUM_W'(acc) + (SUM_W'(bias) <<< FRAC_BITS)) >>> FRAC_BITS;
        if (sum > SAT_MAX) begin
            res = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (sum < SAT_MIN) begin
            res = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            res = sum[DATA_W-1:0];
        end
`ifdef LINEAR_RELU_EN
        res = res[DATA_W-1] ? {DATA_W{1'b0}} : res;
`endif
        return res;
    endfunction

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        i_d         = i_q;
        o_d         = o_q;
        acc_d       = acc_q;
        w_d         = w_q;
        w_ptr_d     = w_ptr_q;
        x_buf_d     = x_buf_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        done_d      = 1'b0;
        prod_s      = PROD_W'(x_buf_q[i_q[IDX_W-1:0]]) * PROD_W'(w_q);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    k_d     = 8'd0;
                    o_d     = 8'd0;
                    w_ptr_d = ADDR_W'(W_BASE);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    x_buf_d[k_q[IDX_W-1:0]] = in_data;
                    if (k_q == IN_LAST) begin
                        state_d = ST_FETCH_W;
                        i_d     = 8'd0;
                        acc_d   = '0;
                    end else begin
                        k_d = k_q + 8'd1;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FETCH_W: begin
                if (wbm_ack_i) begin
                    w_d     = wbm_dat_i;
                    state_d = ST_MAC;
                end else begin
                    state_d = ST_FETCH_W;
                end
            end
            ST_MAC: begin
                acc_d   = acc_q + ACC_W'(prod_s);
                w_ptr_d = w_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (i_q == IN_LAST) begin
                    state_d = ST_FETCH_B;
                end else begin
                    i_d     = i_q + 8'd1;
                    state_d = ST_FETCH_W;
                end
            end
            ST_FETCH_B: begin
                if (wbm_ack_i) begin
                    out_data_d  = sat_result(acc_q, wbm_dat_i);
                    out_index_d = o_q;
                    state_d     = ST_EMIT;
                end else begin
                    state_d = ST_FETCH_B;
                end
            end
            ST_EMIT: begin
                if (out_ready && out_valid_q) begin
                    if (o_q == OUT_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        o_d     = o_q + 8'd1;
                        i_d     = 8'd0;
                        acc_d   = '0;
                        state_d = ST_FETCH_W;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d      = (state_d != ST_IDLE);
        in_ready_d  = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_EMIT);
        cyc_d       = (state_d == ST_FETCH_W) || (state_d == ST_FETCH_B);
        sel_d       = cyc_d ? 4'hF : 4'h0;
        if (state_d == ST_FETCH_W) begin
            adr_d = w_ptr_d;
        end else if (state_d == ST_FETCH_B) begin
            adr_d = ADDR_W'(B_BASE) + ADDR_W'(o_d);
        end else begin
            adr_d = '0;
        end
    end

    // Control, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= 8'd0;
            i_q         <= 8'd0;
            o_q         <= 8'd0;
            acc_q       <= '0;
            w_q         <= '0;
            w_ptr_q     <= '0;
            out_data_q  <= '0;
            out_index_q <= 8'd0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cyc_q       <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            i_q         <= i_d;
            o_q         <= o_d;
            acc_q       <= acc_d;
            w_q         <= w_d;
            w_ptr_q     <= w_ptr_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cyc_q       <= cyc_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
        end
    end

    // Input vector buffer; survives between layer evaluations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < IN_DIM; n++) begin
                x_buf_q[n] <= '0;
            end
        end else begin
            x_buf_q <= x_buf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;

endmodule

// File: tb/tb_linear_mac_engine.sv
// Self-checking bench for linear_mac_engine: directed vector table, wait-state/backpressure,
// mid-operation reset and randomized layers against an arithmetic reference model.
module tb_linear_mac_engine;

    localparam int NI = 4;
    localparam int NO = 3;
    localparam int AW = 10;
    localparam int WB = 16;
    localparam int BB = 100;
    localparam int FB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, busy, done, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data, wbm_dat_i;
    logic [7:0] out_index;
    logic wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;

    linear_mac_engine #(
        .DATA_W(32), .IN_DIM(NI), .OUT_DIM(NO), .ADDR_W(AW),
        .W_BASE(WB), .B_BASE(BB), .FRAC_BITS(FB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    typedef struct packed {
        logic [0:NI-1][31:0]          x;
        logic [0:NO-1][0:NI-1][31:0]  w;
        logic [0:NO-1][31:0]          b;
        logic [0:NO-1][31:0]          e;
    } vec_t;

    vec_t        tbl [3];
    logic [31:0] mem [1024];
    logic [31:0] x_v [NI];
    logic [31:0] w_v [NO][NI];
    logic [31:0] b_v [NO];
    logic [31:0] exp_v [NO];
    logic [AW-1:0] addr_log [$];
    int total = 0;
    int bad = 0;
    int bus_err = 0;
    int stab_err = 0;
    int ack_delay = 1;
    bit spurious = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic logic [31:0] relu_e(input logic [31:0] v);
`ifdef LINEAR_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    // Reference: exact wide arithmetic of sum(x*w) + bias*2^FB, floor-divided by 2^FB, clamped.
    function automatic logic [31:0] ref_out(input int o);
        logic signed [127:0] s, a, b;
        logic [31:0] r;
        s = 128'sd0;
        for (int i = 0; i < NI; i++) begin
            a = 128'(signed'(x_v[i]));
            b = 128'(signed'(w_v[o][i]));
            s = s + a * b;
        end
        a = 128'(signed'(b_v[o]));
        s = (s + (a <<< FB)) >>> FB;
        if (s > 128'sd2147483647) r = 32'h7FFFFFFF;
        else if (s < -128'sd2147483648) r = 32'h80000000;
        else r = s[31:0];
        return relu_e(r);
    endfunction

    // Wishbone slave model with configurable wait states and optional stray acks.
    initial begin
        int cnt;
        cnt = 0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wbm_ack_i = 1'b0;
                cnt = 0;
            end else if (wbm_stb_o && !wbm_ack_i) begin
                if (!wbm_cyc_o || wbm_sel_o !== 4'hF || wbm_we_o !== 1'b0) bus_err++;
                if (cnt >= ack_delay) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = mem[wbm_adr_o];
                    addr_log.push_back(wbm_adr_o);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else if (spurious && !wbm_stb_o) begin
                wbm_ack_i = ~wbm_ack_i;
                wbm_dat_i = 32'hDEADBEEF;
                cnt = 0;
            end else begin
                if (cnt > 0 && !wbm_stb_o) bus_err++;
                if (wbm_ack_i && wbm_stb_o) bus_err++;
                wbm_ack_i = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic load_mem();
        for (int o = 0; o < NO; o++) begin
            for (int i = 0; i < NI; i++) mem[WB + o*NI + i] = w_v[o][i];
            mem[BB + o] = b_v[o];
        end
    endtask

    task automatic use_table(input int t);
        for (int i = 0; i < NI; i++) x_v[i] = tbl[t].x[i];
        for (int o = 0; o < NO; o++) begin
            for (int i = 0; i < NI; i++) w_v[o][i] = tbl[t].w[o][i];
            b_v[o] = tbl[t].b[o];
            exp_v[o] = relu_e(tbl[t].e[o]);
        end
        load_mem();
    endtask

    task automatic start_and_load(input bit gaps);
        int beats;
        bit rdy, fire;
        in_valid = 1'b1;
        in_data = 32'hBAD0BAD0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        chk("in_ready_after_start", {63'd0, in_ready}, 64'd1);
        beats = 0;
        for (int c = 0; c < 200 && beats < NI; c++) begin
            rdy = in_ready;
            in_data = x_v[beats];
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            fire = in_valid && rdy;
            @(negedge clk);
            if (fire) beats++;
        end
        in_valid = 1'b1;
        in_data = 32'h5A5A5A5A;
        chk("load_beats", 64'(beats), 64'(NI));
    endtask

    task automatic run_layer(input int stall, input bit start_in_emit, input bit gaps);
        logic [31:0] got [NO];
        logic [7:0]  gidx [NO];
        logic [31:0] first_d;
        logic [7:0]  first_i;
        logic [AW-1:0] want_adr [$];
        int n, stalled, aerr;
        addr_log.delete();
        start_and_load(gaps);
        n = 0;
        stalled = 0;
        first_d = 32'd0;
        first_i = 8'd0;
        for (int t = 0; t < 3000 && n < NO; t++) begin
            start = 1'b0;
            if (out_valid) begin
                if (stalled == 0) begin
                    first_d = out_data;
                    first_i = out_index;
                end else if (out_data !== first_d || out_index !== first_i) begin
                    stab_err++;
                end
                if (wbm_cyc_o) stab_err++;
                if (stalled < stall) begin
                    out_ready = 1'b0;
                    spurious = (stalled + 1 < stall);
                    if (start_in_emit && stalled == 1) start = 1'b1;
                    stalled++;
                end else begin
                    spurious = 1'b0;
                    out_ready = 1'b1;
                    got[n] = out_data;
                    gidx[n] = out_index;
                    n++;
                    stalled = 0;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        start = 1'b0;
        spurious = 1'b0;
        chk("outputs_seen", 64'(n), 64'(NO));
        chk("done_pulse", {63'd0, done}, 64'd1);
        out_ready = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("done_low", {63'd0, done}, 64'd0);
        chk("busy_idle", {63'd0, busy}, 64'd0);
        for (int o = 0; o < n; o++) begin
            chk("out_index", 64'(gidx[o]), 64'(o));
            chk("out_data", 64'(got[o]), 64'(exp_v[o]));
        end
        for (int o = 0; o < NO; o++) begin
            for (int i = 0; i < NI; i++) want_adr.push_back(AW'(WB + o*NI + i));
            want_adr.push_back(AW'(BB + o));
        end
        aerr = (addr_log.size() == want_adr.size()) ? 0 : 1;
        for (int k = 0; k < want_adr.size() && k < addr_log.size(); k++)
            if (addr_log[k] !== want_adr[k]) aerr++;
        chk("addr_seq", 64'(aerr), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0].x = '{32'd16, 32'd32, 32'd48, 32'd64};
        tbl[0].w = '{'{32'd16, 32'd16, 32'd16, 32'd16},
                     '{32'd32, 32'd0, 32'hFFFFFFF0, 32'd0},
                     '{32'd0, 32'd0, 32'd0, 32'd0}};
        tbl[0].b = '{32'd160, 32'hFFFFFFB0, 32'd7};
        tbl[0].e = '{32'd320, 32'hFFFFFFA0, 32'd7};
        tbl[1].x = '{32'd1, 32'd2, 32'd0, 32'd0};
        tbl[1].w = '{'{32'hFFFFFFFF, 32'd0, 32'd0, 32'd0},
                     '{32'd1, 32'd0, 32'd0, 32'd0},
                     '{32'd30, 32'd5, 32'd0, 32'd0}};
        tbl[1].b = '{32'd0, 32'd0, 32'd0};
        tbl[1].e = '{32'hFFFFFFFF, 32'd0, 32'd2};
        tbl[2].x = '{32'h7FFFFFFF, 32'd0, 32'd0, 32'd0};
        tbl[2].w = '{'{32'h7FFFFFFF, 32'd0, 32'd0, 32'd0},
                     '{32'h80000000, 32'd0, 32'd0, 32'd0},
                     '{32'd0, 32'd0, 32'd0, 32'd0}};
        tbl[2].b = '{32'd0, 32'd0, 32'h7FFFFFFF};
        tbl[2].e = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        for (int a = 0; a < 1024; a++) mem[a] = 32'hCAFE0000 | 32'(a);

        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 32'd0;
        out_ready = 1'b0;
        #23;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_cyc", {63'd0, wbm_cyc_o}, 64'd0);
        chk("rst_stb", {63'd0, wbm_stb_o}, 64'd0);
        chk("rst_we", {63'd0, wbm_we_o}, 64'd0);
        chk("rst_sel", 64'(wbm_sel_o), 64'd0);
        chk("rst_adr", 64'(wbm_adr_o), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_index", 64'(out_index), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 3; t++) begin
            use_table(t);
            ack_delay = 1;
            run_layer(0, 1'b0, 1'b0);
        end

        // Wait states, output backpressure with stray acks, and a start pulse during EMIT.
        use_table(0);
        ack_delay = 4;
        run_layer(5, 1'b1, 1'b1);

        // Asynchronous reset while a weight fetch is outstanding, then a clean rerun.
        use_table(1);
        ack_delay = 3;
        start_and_load(1'b0);
        for (int c = 0; c < 50 && !wbm_stb_o; c++) @(negedge clk);
        chk("stb_before_reset", {63'd0, wbm_stb_o}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", {63'd0, wbm_cyc_o}, 64'd0);
        chk("mid_rst_stb", {63'd0, wbm_stb_o}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_sel", 64'(wbm_sel_o), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        ack_delay = 1;
        run_layer(0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NI; i++)
                x_v[i] = (r % 2 == 0) ? 32'(int'($urandom_range(0, 65535)) - 32768) : $urandom();
            for (int o = 0; o < NO; o++) begin
                for (int i = 0; i < NI; i++)
                    w_v[o][i] = (r % 2 == 0) ? 32'(int'($urandom_range(0, 65535)) - 32768) : $urandom();
                b_v[o] = (r % 2 == 0) ? 32'(int'($urandom_range(0, 65535)) - 32768) : $urandom();
            end
            for (int o = 0; o < NO; o++) exp_v[o] = ref_out(o);
            load_mem();
            ack_delay = $urandom_range(0, 4);
            run_layer($urandom_range(0, 3), 1'b0, 1'b1);
        end

        chk("emit_stable_no_bus", 64'(stab_err), 64'd0);
        chk("bus_protocol", 64'(bus_err), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
